// File: rtl/alu_cmd_issuer.sv
// Registered command front-end for the 8-bit combinational ALU: drives operands, waits
// SETTLE_CYCLES, captures result/flags and returns them over a valid/ready handshake.
//
// state  | meaning
// IDLE   | no operation outstanding, ready for a command
// SETTLE | ALU inputs held, down-counter running toward capture
// RESP   | captured response presented, waiting for rsp_ready_i
module alu_cmd_issuer #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [2:0]       cmd_opcode_i,
    input  logic [7:0]       cmd_a_i,
    input  logic [7:0]       cmd_b_i,
    output logic [2:0]       alu_opcode_o,
    output logic [7:0]       alu_operand1_o,
    output logic [7:0]       alu_operand2_o,
    input  logic [15:0]      alu_result_i,
    input  logic             alu_flag_c_i,
    input  logic             alu_flag_z_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [15:0]      rsp_result_o,
    output logic             rsp_flag_c_o,
    output logic             rsp_flag_z_o,
    output logic [CNT_W-1:0] op_count_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [7:0]       a_q, a_d;
    logic [7:0]       b_q, b_d;
    logic [15:0]      res_q, res_d;
    logic             fc_q, fc_d;
    logic             fz_q, fz_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             accept;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            fc_q    <= 1'b0;
            fz_q    <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            fc_q    <= fc_d;
            fz_q    <= fz_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        fc_d        = fc_q;
        fz_d        = fz_q;
        count_d     = count_q;
        cmd_ready_o = (state_q == IDLE) || ((state_q == RESP) && rsp_ready_i);
        accept      = cmd_valid_i && cmd_ready_o;

        case (state_q)
            IDLE: begin
                if (accept) state_d = SETTLE;
            end
            SETTLE: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    res_d   = alu_result_i;
                    // flagC is only meaningful for ADD/SUB; otherwise the ALU leaves it stale
                    fc_d    = alu_flag_c_i && (op_q[2:1] == 2'b00);
                    fz_d    = alu_flag_z_i;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    count_d = count_q + CNT_W'(1);
                    state_d = accept ? SETTLE : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            op_d  = cmd_opcode_i;
            a_d   = cmd_a_i;
            b_d   = cmd_b_i;
            cnt_d = SETTLE_LOAD;
        end
    end

    assign alu_opcode_o   = op_q;
    assign alu_operand1_o = a_q;
    assign alu_operand2_o = b_q;
    assign rsp_valid_o    = (state_q == RESP);
    assign rsp_result_o   = res_q;
    assign rsp_flag_c_o   = fc_q;
    assign rsp_flag_z_o   = fz_q;
    assign op_count_o     = count_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: two instances (settle 1 / 16-bit count, settle 3 / 4-bit count)
// with a behavioural ALU attached, directed and random traffic against a transaction model.
`timescale 1ns/1ps
module tb_alu_cmd_issuer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0]       cv, cr, rv, rr, fco, fzo, afc, afz;
    logic [1:0][2:0]  cop, aop;
    logic [1:0][7:0]  ca, cb, aa, ab;
    logic [1:0][15:0] ares, rres;
    logic [15:0]      oc0;
    logic [3:0]       oc1;

    function automatic logic [17:0] alu_fn(input logic [2:0] op, input logic [7:0] a,
                                           input logic [7:0] b);
        logic [15:0] r;
        logic        c;
        c = 1'b1;   // flagC stays stale-high for logic/MUL ops
        case (op)
            3'd0: begin r = 16'(a) + 16'(b); c = r[8]; end
            3'd1: begin r = {8'h00, a - b}; c = (a < b); end
            3'd2: r = 16'(a) * 16'(b);
            3'd3: r = {8'h00, a & b};
            3'd4: r = {8'h00, a | b};
            3'd5: r = {8'h00, ~(a & b)};
            3'd6: r = {8'h00, ~(a | b)};
            default: r = {8'h00, a ^ b};
        endcase
        return {c, (r == 16'h0000), r};
    endfunction

    assign {afc[0], afz[0], ares[0]} = alu_fn(aop[0], aa[0], ab[0]);
    assign {afc[1], afz[1], ares[1]} = alu_fn(aop[1], aa[1], ab[1]);

    alu_cmd_issuer #(.SETTLE_CYCLES(1), .CNT_W(16)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(cv[0]), .cmd_ready_o(cr[0]),
        .cmd_opcode_i(cop[0]), .cmd_a_i(ca[0]), .cmd_b_i(cb[0]),
        .alu_opcode_o(aop[0]), .alu_operand1_o(aa[0]), .alu_operand2_o(ab[0]),
        .alu_result_i(ares[0]), .alu_flag_c_i(afc[0]), .alu_flag_z_i(afz[0]),
        .rsp_valid_o(rv[0]), .rsp_ready_i(rr[0]),
        .rsp_result_o(rres[0]), .rsp_flag_c_o(fco[0]), .rsp_flag_z_o(fzo[0]),
        .op_count_o(oc0)
    );

    alu_cmd_issuer #(.SETTLE_CYCLES(3), .CNT_W(4)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(cv[1]), .cmd_ready_o(cr[1]),
        .cmd_opcode_i(cop[1]), .cmd_a_i(ca[1]), .cmd_b_i(cb[1]),
        .alu_opcode_o(aop[1]), .alu_operand1_o(aa[1]), .alu_operand2_o(ab[1]),
        .alu_result_i(ares[1]), .alu_flag_c_i(afc[1]), .alu_flag_z_i(afz[1]),
        .rsp_valid_o(rv[1]), .rsp_ready_i(rr[1]),
        .rsp_result_o(rres[1]), .rsp_flag_c_o(fco[1]), .rsp_flag_z_o(fzo[1]),
        .op_count_o(oc1)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int s_of(input int u);
        return (u == 0) ? 1 : 3;
    endfunction

    function automatic int unsigned cmod(input int u);
        return (u == 0) ? 65536 : 16;
    endfunction

    function automatic logic [15:0] get_oc(input int u);
        return (u == 0) ? oc0 : {12'h000, oc1};
    endfunction

    // transaction-level reference: one outstanding op per unit, absolute accept cycle
    typedef struct {logic [2:0] op; logic [7:0] a; logic [7:0] b;} cmd_t;
    cmd_t        dq[$];
    bit          pend[2], capd[2];
    int          acc[2];
    int unsigned cnt[2];
    logic [2:0]  ex_op[2], l_op[2];
    logic [7:0]  l_a[2], l_b[2];
    logic [15:0] ex_res[2], cap_res[2];
    logic        ex_c[2], ex_z[2], cap_c[2], cap_z[2];

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            pend[u] = 0; capd[u] = 0; cnt[u] = 0;
            l_op[u] = '0; l_a[u] = '0; l_b[u] = '0;
            cap_res[u] = '0; cap_c[u] = 1'b0; cap_z[u] = 1'b0;
        end
    endtask

    task automatic check_outputs(input int u);
        bit vis;
        vis = pend[u] && (cyc >= acc[u] + s_of(u));
        if (vis && !capd[u]) begin
            cap_res[u] = ex_res[u]; cap_c[u] = ex_c[u]; cap_z[u] = ex_z[u]; capd[u] = 1;
        end
        chk("rsp_valid", rv[u], vis);
        chk("rsp_result", rres[u], cap_res[u]);
        chk("rsp_flag_c", fco[u], cap_c[u]);
        chk("rsp_flag_z", fzo[u], cap_z[u]);
        chk("op_count", get_oc(u), cnt[u]);
        chk("alu_opcode", aop[u], l_op[u]);
        chk("alu_operand1", aa[u], l_a[u]);
        chk("alu_operand2", ab[u], l_b[u]);
    endtask

    task automatic run(input int u, input int ncyc, input bit directed);
        cmd_t        c;
        bit          vis_b, hs, accd, exp_rdy;
        logic [17:0] f;
        for (int n = 0; n < ncyc; n++) begin
            if (!cv[u]) begin
                if (directed) begin
                    if (dq.size() > 0) begin
                        c = dq.pop_front();
                        cop[u] = c.op; ca[u] = c.a; cb[u] = c.b; cv[u] = 1'b1;
                    end
                end else if ($urandom_range(0, 3) != 0) begin
                    cop[u] = 3'($urandom);
                    ca[u]  = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
                    cb[u]  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
                    cv[u]  = 1'b1;
                end
            end
            if (directed)
                rr[u] = !(pend[u] && ex_op[u] == 3'd2 && cyc < acc[u] + s_of(u) + 5);
            else
                rr[u] = ($urandom_range(0, 3) != 0);
            #1;
            exp_rdy = !pend[u] || ((cyc >= acc[u] + s_of(u)) && rr[u]);
            chk("cmd_ready", cr[u], exp_rdy);
            @(posedge clk);
            #1;
            vis_b = pend[u] && (cyc - 1 >= acc[u] + s_of(u));
            hs    = vis_b && rr[u];
            accd  = cv[u] && (!pend[u] || hs);
            if (hs) begin
                cnt[u]  = (cnt[u] + 1) % cmod(u);
                pend[u] = 0;
            end
            if (accd) begin
                f         = alu_fn(cop[u], ca[u], cb[u]);
                ex_res[u] = f[15:0];
                ex_z[u]   = f[16];
                ex_c[u]   = (cop[u] <= 3'd1) ? f[17] : 1'b0;
                ex_op[u]  = cop[u];
                l_op[u] = cop[u]; l_a[u] = ca[u]; l_b[u] = cb[u];
                pend[u] = 1; capd[u] = 0; acc[u] = cyc;
                cv[u]   = 1'b0;
            end
            check_outputs(u);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        cv = '0; rr = '0; cop = '0; ca = '0; cb = '0;
        model_reset();
        #22 rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            chk("reset_cmd_ready", cr[u], 1'b1);
            check_outputs(u);
        end

        dq.push_back('{3'd0, 8'd200, 8'd100});
        dq.push_back('{3'd1, 8'd5,   8'd5});
        dq.push_back('{3'd0, 8'hFF,  8'h01});
        dq.push_back('{3'd3, 8'hF0,  8'h0F});
        dq.push_back('{3'd2, 8'hFF,  8'hFF});
        dq.push_back('{3'd7, 8'hAA,  8'h55});
        run(0, 30, 1'b1);
        run(0, 400, 1'b0);
        rr[0] = 1'b0;
        cv[0] = 1'b0;

        // reset while unit 1 is settling
        cop[1] = 3'd4; ca[1] = 8'h12; cb[1] = 8'h34; cv[1] = 1'b1;
        #1 chk("pre_rst_ready", cr[1], 1'b1);
        @(posedge clk);
        #1;
        cv[1] = 1'b0;
        chk("settle_operand1", aa[1], 8'h12);
        chk("settle_valid", rv[1], 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", rv[1], 1'b0);
        chk("rst_ready", cr[1], 1'b1);
        chk("rst_alu_op", aop[1], 3'd0);
        chk("rst_alu_a", aa[1], 8'h00);
        chk("rst_alu_b", ab[1], 8'h00);
        chk("rst_count0", get_oc(0), 16'h0000);
        #4 rst_n = 1'b1;
        model_reset();
        for (int n = 0; n < 6; n++) begin
            @(posedge clk);
            #1;
            chk("post_rst_ready", cr[1], 1'b1);
            check_outputs(1);
        end

        for (int i = 0; i < 16; i++)
            dq.push_back('{3'd4, 8'($urandom), 8'($urandom)});
        run(1, 72, 1'b1);
        chk("wrap_count", get_oc(1), 16'h0000);
        run(1, 400, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
